// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's memory, decode-handshake and control signals.
// With IFU_MISALIGN_TRAP_EN defined it also carries o_misalign.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W    = 10,
    parameter int INSTR_LEN = 32,
    parameter int PC_W      = 32
);
    logic                 i_start;
    logic                 i_halt;
    logic                 i_redirect_valid;
    logic [PC_W-1:0]      i_redirect_pc;
    logic [ADDR_W-1:0]    o_imem_addr;
    logic [INSTR_LEN-1:0] i_imem_data;
    logic                 o_valid;
    logic                 i_ready;
    logic [INSTR_LEN-1:0] o_instr;
    logic [PC_W-1:0]      o_pc;
    logic                 o_busy;
    logic [31:0]          o_fetch_cnt;
`ifdef IFU_MISALIGN_TRAP_EN
    logic                 o_misalign;
`endif

    // Fetch-unit side
    modport master (
        input  i_start, i_halt, i_redirect_valid, i_redirect_pc, i_imem_data, i_ready,
        output o_imem_addr, o_valid, o_instr, o_pc, o_busy, o_fetch_cnt
`ifdef IFU_MISALIGN_TRAP_EN
        , output o_misalign
`endif
    );

    // Environment side (memory, decode, control)
    modport slave (
        output i_start, i_halt, i_redirect_valid, i_redirect_pc, i_imem_data, i_ready,
        input  o_imem_addr, o_valid, o_instr, o_pc, o_busy, o_fetch_cnt
`ifdef IFU_MISALIGN_TRAP_EN
        , input o_misalign
`endif
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the byte PC, addresses instruction memory and registers the fetched
// word into a valid/ready stage for decode. Optional feature macro: IFU_MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
    parameter int              ADDR_W    = 10,
    parameter int              INSTR_LEN = 32,
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}}
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    instruction_fetch_unit_if.master  ifu
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic                 busy_r;
    logic [PC_W-1:0]      pc_r;
    logic [PC_W-1:0]      pc_inc_s;
    logic [PC_W-1:0]      redirect_pc_s;
    logic                 valid_r;
    logic [INSTR_LEN-1:0] instr_r;
    logic [PC_W-1:0]      opc_r;
    logic [31:0]          cnt_r;
    logic                 accept_s;
    logic                 ld_s;
    logic                 start_ok_s;
`ifdef IFU_MISALIGN_TRAP_EN
    logic                 misalign_r;
    logic                 misalign_hit_s;
`endif

    assign accept_s = valid_r && ifu.i_ready;
    assign ld_s     = !valid_r || ifu.i_ready;
    assign pc_inc_s = pc_r + {{(PC_W-3){1'b0}}, 3'b100};

`ifdef IFU_MISALIGN_TRAP_EN
    // Misaligned targets are loaded as-is; the trap flag records the fault.
    assign redirect_pc_s  = ifu.i_redirect_pc;
    assign misalign_hit_s = ifu.i_redirect_valid && (ifu.i_redirect_pc[1:0] != 2'b00);
    assign start_ok_s     = ifu.i_start && !misalign_r;
`else
    assign redirect_pc_s  = ifu.i_redirect_pc & {{(PC_W-2){1'b1}}, 2'b00};
    assign start_ok_s     = ifu.i_start;
`endif

    // Run-control next state; halt wins over start whenever both are requested
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s && !ifu.i_halt) state_nxt_s = ST_RUN;
                else                           state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (ifu.i_halt) state_nxt_s = ST_HALT;
                else            state_nxt_s = ST_RUN;
            end
            ST_HALT: begin
                if (start_ok_s && !ifu.i_halt) state_nxt_s = ST_RUN;
                else                           state_nxt_s = ST_HALT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
`ifdef IFU_MISALIGN_TRAP_EN
        if (misalign_hit_s) state_nxt_s = ST_HALT;
        else                state_nxt_s = state_nxt_s;
`endif
    end

    // FSM state and registered busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    // PC and output stage; a redirect flushes and takes priority over capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r    <= RESET_PC;
            valid_r <= 1'b0;
            instr_r <= {INSTR_LEN{1'b0}};
            opc_r   <= {PC_W{1'b0}};
        end else if (ifu.i_redirect_valid) begin
            pc_r    <= redirect_pc_s;
            valid_r <= 1'b0;
        end else if ((state_r == ST_RUN) && ld_s) begin
            pc_r    <= pc_inc_s;
            valid_r <= 1'b1;
            instr_r <= ifu.i_imem_data;
            opc_r   <= pc_r;
        end else if (accept_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Accepted-instruction counter, wraps naturally at 2**32
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      cnt_r <= 32'd0;
        else if (accept_s) cnt_r <= cnt_r + 32'd1;
        else               cnt_r <= cnt_r;
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Sticky misalignment trap, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            misalign_r <= 1'b0;
        else if (misalign_hit_s) misalign_r <= 1'b1;
        else                     misalign_r <= misalign_r;
    end

    assign ifu.o_misalign = misalign_r;
`endif

    assign ifu.o_imem_addr = pc_r[ADDR_W+1:2];
    assign ifu.o_valid     = valid_r;
    assign ifu.o_instr     = instr_r;
    assign ifu.o_pc        = opc_r;
    assign ifu.o_busy      = busy_r;
    assign ifu.o_fetch_cnt = cnt_r;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit with a word-indexed memory model.
// Expectations for the final misalign rows follow IFU_MISALIGN_TRAP_EN.
module tb_instruction_fetch_unit;
    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    instruction_fetch_unit_if #(.ADDR_W(10), .INSTR_LEN(32), .PC_W(32)) bus ();

    instruction_fetch_unit #(
        .ADDR_W(10), .INSTR_LEN(32), .PC_W(32), .RESET_PC(32'h0000_0000)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .ifu     (bus)
    );

    // Memory model: word n holds C0DE_0000 + n
    assign bus.i_imem_data = 32'hC0DE_0000 + {22'd0, bus.o_imem_addr};

    typedef struct packed {
        logic        start;
        logic        halt;
        logic        rv;
        logic [31:0] rpc;
        logic        ready;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] opc;
        logic [9:0]  addr;
        logic        busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] e(input int n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    function automatic vec_t mk(input logic s, input logic h, input logic rv,
                                input logic [31:0] rpc, input logic rdy,
                                input logic v, input logic [31:0] ins, input logic [31:0] opc,
                                input logic [9:0] a, input logic b, input logic [31:0] c);
        vec_t t;
        t.start = s;  t.halt = h;  t.rv = rv;  t.rpc = rpc;  t.ready = rdy;
        t.valid = v;  t.instr = ins;  t.opc = opc;  t.addr = a;  t.busy = b;  t.cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t t);
        chk({tag, " valid"}, 64'(bus.o_valid),     64'(t.valid));
        chk({tag, " instr"}, 64'(bus.o_instr),     64'(t.instr));
        chk({tag, " pc"},    64'(bus.o_pc),        64'(t.opc));
        chk({tag, " addr"},  64'(bus.o_imem_addr), 64'(t.addr));
        chk({tag, " busy"},  64'(bus.o_busy),      64'(t.busy));
        chk({tag, " cnt"},   64'(bus.o_fetch_cnt), 64'(t.cnt));
    endtask

    // Drive inputs just after an edge, then compare one edge later
    task automatic step(input string tag, input vec_t t);
        bus.i_start          = t.start;
        bus.i_halt           = t.halt;
        bus.i_redirect_valid = t.rv;
        bus.i_redirect_pc    = t.rpc;
        bus.i_ready          = t.ready;
        @(posedge i_clk);
        #1;
        check_outs(tag, t);
    endtask

    initial begin
        bus.i_start = 1'b0;  bus.i_halt = 1'b0;  bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc = 32'd0;  bus.i_ready = 1'b0;

        //          s     h     rv    rpc           rdy   v     instr       opc           addr     busy  cnt
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,      32'h0,        10'd0,   1'b1, 32'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(0),       32'h0,        10'd1,   1'b1, 32'd0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(1),       32'h4,        10'd2,   1'b1, 32'd1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, e(1),       32'h4,        10'd2,   1'b1, 32'd1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, e(1),       32'h4,        10'd2,   1'b1, 32'd1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, e(1),       32'h4,        10'd2,   1'b1, 32'd1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(2),       32'h8,        10'd3,   1'b1, 32'd2));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 1'b0, e(2),       32'h8,        10'h10,  1'b1, 32'd3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(16),      32'h40,       10'h11,  1'b1, 32'd3));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(17),      32'h44,       10'h12,  1'b1, 32'd4));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, e(17),      32'h44,       10'h12,  1'b0, 32'd4));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, e(17),      32'h44,       10'h12,  1'b0, 32'd4));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, e(17),      32'h44,       10'h12,  1'b0, 32'd5));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, e(17),      32'h44,       10'h12,  1'b1, 32'd5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(18),      32'h48,       10'h13,  1'b1, 32'd5));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, e(18),      32'h48,       10'd1023, 1'b1, 32'd6));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(1023),    32'hFFFFFFFC, 10'd0,   1'b1, 32'd6));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(0),       32'h0,        10'd1,   1'b1, 32'd7));
`ifdef IFU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h22,       1'b1, 1'b0, e(0),       32'h0,        10'd8,   1'b0, 32'd8));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, e(0),       32'h0,        10'd8,   1'b0, 32'd8));
`else
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h22,       1'b1, 1'b0, e(0),       32'h0,        10'd8,   1'b1, 32'd8));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, e(8),       32'h20,       10'd9,   1'b1, 32'd8));
`endif

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check_outs("reset", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                               1'b0, 32'h0, 32'h0, 10'd0, 1'b0, 32'd0));
`ifdef IFU_MISALIGN_TRAP_EN
        chk("reset misalign", 64'(bus.o_misalign), 64'd0);
`endif
        i_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end
`ifdef IFU_MISALIGN_TRAP_EN
        chk("trap misalign", 64'(bus.o_misalign), 64'd1);
`endif

        // Fresh reset, then redirect while IDLE, halt-beats-start, and mid-run async reset
        i_rst_n = 1'b0;
        #2;
        i_rst_n = 1'b1;
        step("idle_redir", mk(1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 10'h40, 1'b0, 32'd0));
        step("idle_start", mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 32'h0, 10'h40, 1'b1, 32'd0));
        step("tgt_fetch",  mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, e(64), 32'h100, 10'h41, 1'b1, 32'd0));
        step("run_both",   mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, e(64), 32'h100, 10'h41, 1'b0, 32'd0));
        step("halt_both",  mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, e(64), 32'h100, 10'h41, 1'b0, 32'd1));
        step("restart",    mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, e(64), 32'h100, 10'h41, 1'b1, 32'd1));
        step("resume",     mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, e(65), 32'h104, 10'h42, 1'b1, 32'd1));
        i_rst_n = 1'b0;
        #2;
        check_outs("async_rst", mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
                                   1'b0, 32'h0, 32'h0, 10'd0, 1'b0, 32'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
